// File: rtl/axi_sram_wr_arbiter_if.sv
// ----------------------------------------------------------------------------
// axi_sram_wr_arbiter_if
//   Write-only AXI subset (AW, W, B) used between the SRAM write masters, the
//   write arbiter and the axi_sram_controller write port.
//
//   master modport : drives AW/W payload and valids, drives bready
//   slave modport  : drives awready/wready, drives B response
// ----------------------------------------------------------------------------
interface axi_sram_wr_arbiter_if #(
    parameter int AXI_ADDR_WIDTH = 20,
    parameter int AXI_DATA_WIDTH = 16
);
    localparam int STRB_WIDTH = (AXI_DATA_WIDTH + 7) / 8;

    logic [AXI_ADDR_WIDTH-1:0] awaddr;
    logic                      awvalid;
    logic                      awready;
    logic [AXI_DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0]     wstrb;
    logic                      wvalid;
    logic                      wready;
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bvalid, bresp
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bvalid, bresp
    );
endinterface

// File: rtl/axi_sram_wr_arbiter.sv
// ----------------------------------------------------------------------------
// axi_sram_wr_arbiter
//   Shares the single AXI write port of axi_sram_controller between two write
//   masters (m0 = fb_writer / gfx path, m1 = framebuffer fill/clear engine).
//   One transaction in flight at a time; the owner is chosen in IDLE from the
//   masters' awvalid (wvalid alone never requests) and registered in grant.
//
// Ports:
//   axi_clk     in   clock, rising edge
//   axi_resetn  in   asynchronous active-low reset
//   m0_axi      slave modport of axi_sram_wr_arbiter_if, master 0
//   m1_axi      slave modport of axi_sram_wr_arbiter_if, master 1
//   s_axi       master modport of axi_sram_wr_arbiter_if, to the controller
//   grant       out  one-hot owner (01 = m0, 10 = m1), 00 when idle
//
// Build option:
//   AXI_SRAM_WR_ARBITER_RR_EN  defined   : round-robin on simultaneous requests
//                              undefined : fixed priority, m0 always wins ties
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no owner; all handshakes to masters and controller held low
// DATA  | owner's AW and W forwarded; sticky done flags mask finished channels
// RESP  | controller B forwarded to owner; leaves on the B handshake
// ----------------------------------------------------------------------------
module axi_sram_wr_arbiter #(
    parameter int AXI_ADDR_WIDTH = 20,
    parameter int AXI_DATA_WIDTH = 16
) (
    input  logic                   axi_clk,
    input  logic                   axi_resetn,
    axi_sram_wr_arbiter_if.slave   m0_axi,
    axi_sram_wr_arbiter_if.slave   m1_axi,
    axi_sram_wr_arbiter_if.master  s_axi,
    output logic [1:0]             grant
);
    localparam int STRB_WIDTH = (AXI_DATA_WIDTH + 7) / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;

`ifdef AXI_SRAM_WR_ARBITER_RR_EN
    // 1: m1 owned the previous transaction, 0: m0 did
    logic       last_grant_q, last_grant_d;
`endif

    logic                      pick_m1;
    logic                      aw_hs, w_hs, b_hs;

    // owner-side view, selected by the registered grant
    logic [AXI_ADDR_WIDTH-1:0] own_awaddr;
    logic                      own_awvalid;
    logic [AXI_DATA_WIDTH-1:0] own_wdata;
    logic [STRB_WIDTH-1:0]     own_wstrb;
    logic                      own_wvalid;
    logic                      own_bready;
    logic                      own_awready, own_wready, own_bvalid;
    logic [1:0]                own_bresp;

    assign grant = grant_q;

    // Arbitration: a lone requester always wins; a tie goes by the build option.
    always_comb begin
`ifdef AXI_SRAM_WR_ARBITER_RR_EN
        pick_m1 = m1_axi.awvalid && (!m0_axi.awvalid || !last_grant_q);
`else
        pick_m1 = m1_axi.awvalid && !m0_axi.awvalid;
`endif
    end

    always_comb begin
        if (grant_q[1]) begin
            own_awaddr  = m1_axi.awaddr;
            own_awvalid = m1_axi.awvalid;
            own_wdata   = m1_axi.wdata;
            own_wstrb   = m1_axi.wstrb;
            own_wvalid  = m1_axi.wvalid;
            own_bready  = m1_axi.bready;
        end else begin
            own_awaddr  = m0_axi.awaddr;
            own_awvalid = m0_axi.awvalid;
            own_wdata   = m0_axi.wdata;
            own_wstrb   = m0_axi.wstrb;
            own_wvalid  = m0_axi.wvalid;
            own_bready  = m0_axi.bready;
        end
    end

    // Output forwarding; everything defaults low so the non-owner and IDLE
    // never see a ready or a response.
    always_comb begin
        s_axi.awaddr   = '0;
        s_axi.awvalid  = 1'b0;
        s_axi.wdata    = '0;
        s_axi.wstrb    = '0;
        s_axi.wvalid   = 1'b0;
        s_axi.bready   = 1'b0;
        own_awready    = 1'b0;
        own_wready     = 1'b0;
        own_bvalid     = 1'b0;
        own_bresp      = 2'b00;
        m0_axi.awready = 1'b0;
        m0_axi.wready  = 1'b0;
        m0_axi.bvalid  = 1'b0;
        m0_axi.bresp   = 2'b00;
        m1_axi.awready = 1'b0;
        m1_axi.wready  = 1'b0;
        m1_axi.bvalid  = 1'b0;
        m1_axi.bresp   = 2'b00;

        case (state_q)
            ST_DATA: begin
                // a finished channel is masked so the controller sees it once
                s_axi.awaddr  = own_awaddr;
                s_axi.awvalid = own_awvalid && !aw_done_q;
                s_axi.wdata   = own_wdata;
                s_axi.wstrb   = own_wstrb;
                s_axi.wvalid  = own_wvalid && !w_done_q;
                own_awready   = s_axi.awready && !aw_done_q;
                own_wready    = s_axi.wready && !w_done_q;
            end
            ST_RESP: begin
                own_bvalid   = s_axi.bvalid;
                own_bresp    = s_axi.bresp;
                s_axi.bready = own_bready;
            end
            default: begin
            end
        endcase

        if (grant_q[0]) begin
            m0_axi.awready = own_awready;
            m0_axi.wready  = own_wready;
            m0_axi.bvalid  = own_bvalid;
            m0_axi.bresp   = own_bresp;
        end
        if (grant_q[1]) begin
            m1_axi.awready = own_awready;
            m1_axi.wready  = own_wready;
            m1_axi.bvalid  = own_bvalid;
            m1_axi.bresp   = own_bresp;
        end
    end

    assign aw_hs = s_axi.awvalid && s_axi.awready;
    assign w_hs  = s_axi.wvalid && s_axi.wready;
    assign b_hs  = s_axi.bvalid && s_axi.bready;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
`ifdef AXI_SRAM_WR_ARBITER_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (m0_axi.awvalid || m1_axi.awvalid) begin
                    state_d = ST_DATA;
                    grant_d = pick_m1 ? 2'b10 : 2'b01;
                end
            end
            ST_DATA: begin
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                if (aw_done_d && w_done_d) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (b_hs) begin
                    state_d   = ST_IDLE;
                    grant_d   = 2'b00;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
`ifdef AXI_SRAM_WR_ARBITER_RR_EN
                    last_grant_d = grant_q[1];
`endif
                end
            end
            default: begin
                state_d   = ST_IDLE;
                grant_d   = 2'b00;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q   <= ST_IDLE;
            grant_q   <= 2'b00;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

`ifdef AXI_SRAM_WR_ARBITER_RR_EN
    // resets to m1 so that m0 wins the first tie
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

endmodule

// File: tb/tb_axi_sram_wr_arbiter.sv
module tb_axi_sram_wr_arbiter;
    localparam int AW = 20;
    localparam int DW = 16;
    localparam int SW = (DW + 7) / 8;

    logic       axi_clk = 1'b0;
    logic       axi_resetn = 1'b0;
    logic [1:0] grant;
    int         checks = 0;
    int         failures = 0;

    axi_sram_wr_arbiter_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) m0_if ();
    axi_sram_wr_arbiter_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) m1_if ();
    axi_sram_wr_arbiter_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) s_if ();

    axi_sram_wr_arbiter #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
        .axi_clk    (axi_clk),
        .axi_resetn (axi_resetn),
        .m0_axi     (m0_if),
        .m1_axi     (m1_if),
        .s_axi      (s_if),
        .grant      (grant)
    );

    always #5 axi_clk = ~axi_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // random-test bookkeeping
    logic [AW-1:0]    aw_q0[$], aw_q1[$], exp_a0[$], exp_a1[$], got_addr[$];
    logic [DW+SW-1:0] w_q0[$], w_q1[$], exp_w0[$], exp_w1[$], got_w[$];
    logic [2:0]       got_b[$];
    logic [1:0]       sent_b[$];
    int               s_aw_cnt, s_w_cnt, s_b_cnt, viol;

    function automatic logic [12:0] ctrl_outs();
        return {m0_if.awready, m0_if.wready, m0_if.bvalid, m0_if.bresp,
                m1_if.awready, m1_if.wready, m1_if.bvalid, m1_if.bresp,
                s_if.awvalid, s_if.wvalid, s_if.bready};
    endfunction

    task automatic idle_inputs();
        m0_if.awaddr = '0; m0_if.awvalid = 1'b0; m0_if.wdata = '0; m0_if.wstrb = '0;
        m0_if.wvalid = 1'b0; m0_if.bready = 1'b0;
        m1_if.awaddr = '0; m1_if.awvalid = 1'b0; m1_if.wdata = '0; m1_if.wstrb = '0;
        m1_if.wvalid = 1'b0; m1_if.bready = 1'b0;
        s_if.awready = 1'b0; s_if.wready = 1'b0; s_if.bvalid = 1'b0; s_if.bresp = 2'b00;
    endtask

    task automatic do_reset();
        @(posedge axi_clk); #1;
        axi_resetn = 1'b0;
        idle_inputs();
        repeat (2) @(posedge axi_clk);
        #1 axi_resetn = 1'b1;
    endtask

    task automatic test_reset();
        axi_resetn = 1'b0;
        idle_inputs();
        m0_if.awvalid = 1'b1; m0_if.wvalid = 1'b1; m0_if.bready = 1'b1;
        s_if.awready = 1'b1; s_if.wready = 1'b1; s_if.bvalid = 1'b1;
        repeat (3) @(posedge axi_clk);
        @(negedge axi_clk);
        checks++;
        if (grant !== 2'b00) begin
            failures++; $display("FAIL reset_grant: got %b expected 00", grant);
        end
        checks++;
        if (ctrl_outs() !== 13'h0) begin
            failures++; $display("FAIL reset_outs: got %h expected 0", ctrl_outs());
        end
        idle_inputs();
        @(posedge axi_clk); #1 axi_resetn = 1'b1;
        @(negedge axi_clk);
        checks++;
        if (grant !== 2'b00) begin
            failures++; $display("FAIL reset_release_grant: got %b expected 00", grant);
        end
    endtask

    task automatic test_single_m0();
        @(posedge axi_clk); #1;
        m0_if.awaddr = 20'h00123; m0_if.awvalid = 1'b1;
        m0_if.wdata = 16'h0F0F; m0_if.wstrb = 2'b11; m0_if.wvalid = 1'b1;
        s_if.awready = 1'b1; s_if.wready = 1'b1;
        @(negedge axi_clk);
        checks++;
        if ({grant, s_if.awvalid} !== 3'b000) begin
            failures++; $display("FAIL single_latency: got grant/awvalid %b expected 000", {grant, s_if.awvalid});
        end
        @(negedge axi_clk);
        checks++;
        if (grant !== 2'b01) begin
            failures++; $display("FAIL single_grant: got %b expected 01", grant);
        end
        checks++;
        if (s_if.awaddr !== 20'h00123) begin
            failures++; $display("FAIL single_awaddr: got %h expected 00123", s_if.awaddr);
        end
        checks++;
        if ({s_if.wdata, s_if.wstrb} !== {16'h0F0F, 2'b11}) begin
            failures++; $display("FAIL single_wdata: got %h/%b expected 0f0f/11", s_if.wdata, s_if.wstrb);
        end
        checks++;
        if ({s_if.awvalid, s_if.wvalid, m0_if.awready, m0_if.wready, m1_if.awready, m1_if.wready} !== 6'b111100) begin
            failures++; $display("FAIL single_handshake: got %b expected 111100",
                {s_if.awvalid, s_if.wvalid, m0_if.awready, m0_if.wready, m1_if.awready, m1_if.wready});
        end
        @(posedge axi_clk); #1;
        m0_if.awvalid = 1'b0; m0_if.wvalid = 1'b0;
        s_if.bvalid = 1'b1; s_if.bresp = 2'b00; m0_if.bready = 1'b1;
        @(negedge axi_clk);
        checks++;
        if ({s_if.awvalid, s_if.wvalid, m0_if.bvalid, m0_if.bresp, s_if.bready, m1_if.bvalid} !== 7'b0010010) begin
            failures++; $display("FAIL single_resp: got %b expected 0010010",
                {s_if.awvalid, s_if.wvalid, m0_if.bvalid, m0_if.bresp, s_if.bready, m1_if.bvalid});
        end
        @(posedge axi_clk); #1;
        idle_inputs();
        @(negedge axi_clk);
        checks++;
        if (grant !== 2'b00) begin
            failures++; $display("FAIL single_release: got %b expected 00", grant);
        end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] resp;
        resp = 2'($urandom_range(1, 3));
        @(posedge axi_clk); #1;
        m1_if.wdata = 16'hABCD; m1_if.wstrb = 2'b11; m1_if.wvalid = 1'b1;
        s_if.awready = 1'b1; s_if.wready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge axi_clk);
            checks++;
            if ({grant, s_if.wvalid, m1_if.wready} !== 4'b0000) begin
                failures++; $display("FAIL wfirst_nogrant cycle %0d: got %b expected 0000", i,
                    {grant, s_if.wvalid, m1_if.wready});
            end
        end
        @(posedge axi_clk); #1;
        m1_if.awaddr = 20'h00400; m1_if.awvalid = 1'b1;
        @(negedge axi_clk);
        @(negedge axi_clk);
        checks++;
        if (grant !== 2'b10) begin
            failures++; $display("FAIL wfirst_grant: got %b expected 10", grant);
        end
        checks++;
        if ({s_if.awaddr, s_if.wdata, s_if.awvalid, s_if.wvalid} !== {20'h00400, 16'hABCD, 2'b11}) begin
            failures++; $display("FAIL wfirst_fwd: got %h %h %b expected 00400 abcd 11",
                s_if.awaddr, s_if.wdata, {s_if.awvalid, s_if.wvalid});
        end
        @(posedge axi_clk); #1;
        m1_if.awvalid = 1'b0; m1_if.wvalid = 1'b0;
        s_if.bvalid = 1'b1; s_if.bresp = resp; m1_if.bready = 1'b1;
        @(negedge axi_clk);
        checks++;
        if ({m1_if.bvalid, m1_if.bresp, m0_if.bvalid, m0_if.bresp} !== {1'b1, resp, 3'b000}) begin
            failures++; $display("FAIL wfirst_bresp: got %b expected %b",
                {m1_if.bvalid, m1_if.bresp, m0_if.bvalid, m0_if.bresp}, {1'b1, resp, 3'b000});
        end
        @(posedge axi_clk); #1;
        idle_inputs();
    endtask

    task automatic test_split();
        logic [AW-1:0] addr;
        addr = AW'($urandom);
        @(posedge axi_clk); #1;
        m0_if.awaddr = addr; m0_if.awvalid = 1'b1;
        m0_if.wdata = 16'h1234; m0_if.wstrb = 2'b01; m0_if.wvalid = 1'b1;
        s_if.bvalid = 1'b1; s_if.bresp = 2'b10; m0_if.bready = 1'b1;
        @(posedge axi_clk); #1;
        s_if.awready = 1'b1;
        @(negedge axi_clk);
        checks++;
        if ({s_if.awaddr, s_if.awvalid, s_if.bready} !== {addr, 2'b10}) begin
            failures++; $display("FAIL split_aw: got %h %b expected %h 10",
                s_if.awaddr, {s_if.awvalid, s_if.bready}, addr);
        end
        for (int c = 2; c <= 4; c++) begin
            @(posedge axi_clk); #1;
            if (c == 2) begin
                s_if.awready = 1'b0; m0_if.awvalid = 1'b0;
            end
            if (c == 4) s_if.wready = 1'b1;
            @(negedge axi_clk);
            checks++;
            if ({s_if.awvalid, s_if.wvalid, s_if.bready} !== 3'b010) begin
                failures++; $display("FAIL split_wait cycle %0d: got %b expected 010", c,
                    {s_if.awvalid, s_if.wvalid, s_if.bready});
            end
        end
        @(posedge axi_clk); #1;
        m0_if.wvalid = 1'b0; s_if.wready = 1'b0;
        @(negedge axi_clk);
        checks++;
        if ({s_if.bready, m0_if.bvalid, m0_if.bresp} !== 4'b1110) begin
            failures++; $display("FAIL split_resp: got %b expected 1110",
                {s_if.bready, m0_if.bvalid, m0_if.bresp});
        end
        @(posedge axi_clk); #1;
        idle_inputs();
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] a1;
        a1 = AW'($urandom);
        @(posedge axi_clk); #1;
        m0_if.awaddr = AW'($urandom); m0_if.awvalid = 1'b1; m0_if.wvalid = 1'b1; m0_if.wstrb = 2'b11;
        s_if.awready = 1'b1; s_if.wready = 1'b1;
        repeat (2) @(posedge axi_clk);
        #1;
        m0_if.awvalid = 1'b0; m0_if.wvalid = 1'b0;
        s_if.bvalid = 1'b1; s_if.bresp = 2'b01; m0_if.bready = 1'b0;
        m1_if.awaddr = a1; m1_if.awvalid = 1'b1; m1_if.wdata = 16'h5A5A; m1_if.wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge axi_clk);
            checks++;
            if ({s_if.bready, m0_if.bvalid, grant, m1_if.awready, m1_if.wready} !== 6'b010100) begin
                failures++; $display("FAIL bp_hold cycle %0d: got %b expected 010100", i,
                    {s_if.bready, m0_if.bvalid, grant, m1_if.awready, m1_if.wready});
            end
            @(posedge axi_clk); #1;
        end
        m0_if.bready = 1'b1;
        @(negedge axi_clk);
        checks++;
        if (s_if.bready !== 1'b1) begin
            failures++; $display("FAIL bp_bready: got %b expected 1", s_if.bready);
        end
        @(posedge axi_clk); #1;
        m0_if.bready = 1'b0; s_if.bvalid = 1'b0;
        @(negedge axi_clk);
        checks++;
        if (grant !== 2'b00) begin
            failures++; $display("FAIL bp_idle_gap: got %b expected 00", grant);
        end
        @(negedge axi_clk);
        checks++;
        if ({grant, s_if.awaddr} !== {2'b10, a1}) begin
            failures++; $display("FAIL bp_next_grant: got %b %h expected 10 %h", grant, s_if.awaddr, a1);
        end
        @(posedge axi_clk); #1;
        m1_if.awvalid = 1'b0; m1_if.wvalid = 1'b0;
        s_if.bvalid = 1'b1; m1_if.bready = 1'b1;
        @(posedge axi_clk); #1;
        idle_inputs();
    endtask

    task automatic test_reset_mid_data();
        @(posedge axi_clk); #1;
        m0_if.awaddr = AW'($urandom); m0_if.awvalid = 1'b1; m0_if.wvalid = 1'b1; m0_if.wdata = 16'h7777;
        s_if.awready = 1'b1; s_if.wready = 1'b0;
        repeat (2) @(posedge axi_clk);
        #1 m0_if.awvalid = 1'b0;
        @(negedge axi_clk);
        checks++;
        if ({grant, s_if.awvalid, s_if.wvalid} !== 4'b0101) begin
            failures++; $display("FAIL rstmid_pre: got %b expected 0101", {grant, s_if.awvalid, s_if.wvalid});
        end
        #2 axi_resetn = 1'b0;
        #1;
        checks++;
        if ({grant, ctrl_outs()} !== 15'h0) begin
            failures++; $display("FAIL rstmid_async: got %b %h expected 00 0", grant, ctrl_outs());
        end
        idle_inputs();
        @(posedge axi_clk); #1;
        @(posedge axi_clk); #1;
        axi_resetn = 1'b1;
        m1_if.awaddr = 20'h00777; m1_if.awvalid = 1'b1; m1_if.wdata = 16'h0101; m1_if.wvalid = 1'b1;
        s_if.awready = 1'b1; s_if.wready = 1'b1;
        @(negedge axi_clk);
        @(negedge axi_clk);
        checks++;
        if ({grant, s_if.awaddr, s_if.awvalid, s_if.wvalid} !== {2'b10, 20'h00777, 2'b11}) begin
            failures++; $display("FAIL rstmid_m1: got %b %h %b expected 10 00777 11",
                grant, s_if.awaddr, {s_if.awvalid, s_if.wvalid});
        end
        @(posedge axi_clk); #1;
        m1_if.awvalid = 1'b0; m1_if.wvalid = 1'b0;
        s_if.bvalid = 1'b1; m1_if.bready = 1'b1;
        @(negedge axi_clk);
        checks++;
        if ({m1_if.bvalid, m0_if.bvalid} !== 2'b10) begin
            failures++; $display("FAIL rstmid_b: got %b expected 10", {m1_if.bvalid, m0_if.bvalid});
        end
        @(posedge axi_clk); #1;
        idle_inputs();
        @(negedge axi_clk);
        checks++;
        if (grant !== 2'b00) begin
            failures++; $display("FAIL rstmid_done: got %b expected 00", grant);
        end
    endtask

    task automatic test_tie();
        logic [1:0]    gseq[3];
        logic [AW-1:0] aseq[3];
        logic [1:0]    exp_g[3];
        logic [1:0]    prev_g;
        int            ng, naw;
`ifdef AXI_SRAM_WR_ARBITER_RR_EN
        exp_g = '{2'b01, 2'b10, 2'b01};
`else
        exp_g = '{2'b01, 2'b01, 2'b01};
`endif
        do_reset();
        m0_if.awaddr = 20'h0AAAA; m0_if.awvalid = 1'b1; m0_if.wvalid = 1'b1;
        m1_if.awaddr = 20'h05555; m1_if.awvalid = 1'b1; m1_if.wvalid = 1'b1;
        s_if.awready = 1'b1; s_if.wready = 1'b1; s_if.bvalid = 1'b1;
        m0_if.bready = 1'b1; m1_if.bready = 1'b1;
        prev_g = 2'b00; ng = 0; naw = 0;
        for (int cyc = 0; cyc < 40 && ng < 3; cyc++) begin
            @(negedge axi_clk);
            if (grant !== 2'b00 && prev_g === 2'b00) begin
                gseq[ng] = grant; ng++;
            end
            if (s_if.awvalid && s_if.awready) begin
                if (naw < 3) aseq[naw] = s_if.awaddr;
                naw++;
            end
            prev_g = grant;
        end
        checks++;
        if (ng != 3) begin
            failures++; $display("FAIL tie_rounds: got %0d grants expected 3", ng);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (gseq[i] !== exp_g[i]) begin
                    failures++; $display("FAIL tie_grant round %0d: got %b expected %b", i, gseq[i], exp_g[i]);
                end
                checks++;
                if (aseq[i] !== ((exp_g[i] == 2'b01) ? 20'h0AAAA : 20'h05555)) begin
                    failures++; $display("FAIL tie_addr round %0d: got %h expected %h", i, aseq[i],
                        (exp_g[i] == 2'b01) ? 20'h0AAAA : 20'h05555);
                end
            end
            checks++;
            if (naw != 3) begin
                failures++; $display("FAIL tie_aw_count: got %0d expected 3", naw);
            end
        end
        @(posedge axi_clk); #1;
        m0_if.awvalid = 1'b0; m0_if.wvalid = 1'b0; m1_if.awvalid = 1'b0; m1_if.wvalid = 1'b0;
        @(posedge axi_clk); #1;
        idle_inputs();
        @(posedge axi_clk); #1;
    endtask

    // One clock of the random traffic: sample handshakes at the negedge, then
    // advance the master and controller models just after the rising edge.
    task automatic step();
        logic h0_aw, h0_w, h0_b, h1_aw, h1_w, h1_b, hs_aw, hs_w, hs_b;
        @(negedge axi_clk);
        h0_aw = m0_if.awvalid && m0_if.awready;  h0_w = m0_if.wvalid && m0_if.wready;
        h0_b  = m0_if.bvalid && m0_if.bready;
        h1_aw = m1_if.awvalid && m1_if.awready;  h1_w = m1_if.wvalid && m1_if.wready;
        h1_b  = m1_if.bvalid && m1_if.bready;
        hs_aw = s_if.awvalid && s_if.awready;    hs_w = s_if.wvalid && s_if.wready;
        hs_b  = s_if.bvalid && s_if.bready;
        if (hs_aw) got_addr.push_back(s_if.awaddr);
        if (hs_w)  got_w.push_back({s_if.wdata, s_if.wstrb});
        if (h0_b)  got_b.push_back({1'b0, m0_if.bresp});
        if (h1_b)  got_b.push_back({1'b1, m1_if.bresp});
        if (grant === 2'b11 || $isunknown(grant)) viol++;
        if (grant !== 2'b01 && {m0_if.awready, m0_if.wready, m0_if.bvalid, m0_if.bresp} !== 5'b0) viol++;
        if (grant !== 2'b10 && {m1_if.awready, m1_if.wready, m1_if.bvalid, m1_if.bresp} !== 5'b0) viol++;
        @(posedge axi_clk); #1;
        if (h0_aw) void'(aw_q0.pop_front());
        if (h1_aw) void'(aw_q1.pop_front());
        if (h0_w) begin void'(w_q0.pop_front()); m0_if.wvalid = 1'b0; end
        if (h1_w) begin void'(w_q1.pop_front()); m1_if.wvalid = 1'b0; end
        if (hs_aw) s_aw_cnt++;
        if (hs_w)  s_w_cnt++;
        if (hs_b) begin s_if.bvalid = 1'b0; s_b_cnt++; end
        m0_if.awvalid = (aw_q0.size() != 0);
        if (aw_q0.size() != 0) m0_if.awaddr = aw_q0[0];
        m1_if.awvalid = (aw_q1.size() != 0);
        if (aw_q1.size() != 0) m1_if.awaddr = aw_q1[0];
        if (w_q0.size() != 0 && !m0_if.wvalid && $urandom_range(0, 1) == 1) begin
            m0_if.wvalid = 1'b1; {m0_if.wdata, m0_if.wstrb} = w_q0[0];
        end
        if (w_q1.size() != 0 && !m1_if.wvalid && $urandom_range(0, 1) == 1) begin
            m1_if.wvalid = 1'b1; {m1_if.wdata, m1_if.wstrb} = w_q1[0];
        end
        m0_if.bready = 1'($urandom_range(0, 1));
        m1_if.bready = 1'($urandom_range(0, 1));
        s_if.awready = ($urandom_range(0, 3) != 0);
        s_if.wready  = ($urandom_range(0, 3) != 0);
        if (!s_if.bvalid && s_aw_cnt > s_b_cnt && s_w_cnt > s_b_cnt && $urandom_range(0, 1) == 1) begin
            s_if.bvalid = 1'b1;
            s_if.bresp  = 2'($urandom_range(0, 3));
            sent_b.push_back(s_if.bresp);
        end
    endtask

    task automatic test_random();
        int            n0, n1, total, rem0, rem1, cyc;
        bit            last, pick;
        bit            exp_owner[$];
        logic [AW-1:0] ea;
        logic [DW+SW-1:0] ew;
        do_reset();
        s_aw_cnt = 0; s_w_cnt = 0; s_b_cnt = 0; viol = 0;
        n0 = $urandom_range(3, 6); n1 = $urandom_range(3, 6); total = n0 + n1;
        for (int k = 0; k < n0; k++) begin
            ea = {1'b0, 3'(k), 16'($urandom)}; ew = (DW+SW)'($urandom);
            aw_q0.push_back(ea); exp_a0.push_back(ea); w_q0.push_back(ew); exp_w0.push_back(ew);
        end
        for (int k = 0; k < n1; k++) begin
            ea = {1'b1, 3'(k), 16'($urandom)}; ew = (DW+SW)'($urandom);
            aw_q1.push_back(ea); exp_a1.push_back(ea); w_q1.push_back(ew); exp_w1.push_back(ew);
        end
        // both masters keep a request pending, so every arbitration is a tie
        // until one of them runs dry
        rem0 = n0; rem1 = n1; last = 1'b1;
        while (rem0 + rem1 > 0) begin
            if (rem0 > 0 && rem1 > 0) begin
`ifdef AXI_SRAM_WR_ARBITER_RR_EN
                pick = !last;
`else
                pick = 1'b0;
`endif
            end else begin
                pick = (rem0 == 0);
            end
            exp_owner.push_back(pick);
            last = pick;
            if (pick) rem1--; else rem0--;
        end
        cyc = 0;
        while (got_b.size() < total && cyc < 3000) begin
            step();
            cyc++;
        end
        checks++;
        if (got_b.size() != total) begin
            failures++; $display("FAIL rand_complete: got %0d responses expected %0d", got_b.size(), total);
        end
        checks++;
        if (viol != 0) begin
            failures++; $display("FAIL rand_exclusive: got %0d violations expected 0", viol);
        end
        for (int k = 0; k < total; k++) begin
            if (exp_owner[k]) begin ea = exp_a1.pop_front(); ew = exp_w1.pop_front(); end
            else begin ea = exp_a0.pop_front(); ew = exp_w0.pop_front(); end
            checks++;
            if (k >= got_addr.size() || got_addr[k] !== ea) begin
                failures++; $display("FAIL rand_addr txn %0d: got %h expected %h", k,
                    (k < got_addr.size()) ? got_addr[k] : 'x, ea);
            end
            checks++;
            if (k >= got_w.size() || got_w[k] !== ew) begin
                failures++; $display("FAIL rand_wdata txn %0d: got %h expected %h", k,
                    (k < got_w.size()) ? got_w[k] : 'x, ew);
            end
            checks++;
            if (k >= got_b.size() || k >= sent_b.size() || got_b[k] !== {exp_owner[k], sent_b[k]}) begin
                failures++; $display("FAIL rand_bresp txn %0d: got %b expected owner %0d resp %b", k,
                    (k < got_b.size()) ? got_b[k] : 'x, exp_owner[k],
                    (k < sent_b.size()) ? sent_b[k] : 2'bxx);
            end
        end
        @(posedge axi_clk); #1;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_m0();
        test_w_before_aw();
        test_split();
        test_backpressure();
        test_reset_mid_data();
        test_tie();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
